// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
// Owns the PC, keeps at most one instruction-memory read open, buffers one
// instruction in a skid register under ID back-pressure, and restarts on
// redirects while discarding any wrong-path read still in flight.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic [63:0] if_nextseqpc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;
  localparam logic [63:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

  logic [1:0]  state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [63:0] if_nextseqpc_q, if_nextseqpc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [63:0] skid_pc_q, skid_pc_d;

  logic [63:0] redir_tgt;
  logic [63:0] fetch_pc_inc;
  logic [63:0] skid_pc_inc;
  logic        out_free;
  logic        consumed;

  assign redir_tgt    = redirect_pc & PC_ALIGN_MASK;
  assign fetch_pc_inc = fetch_pc_q + 64'd4;
  assign skid_pc_inc  = skid_pc_q + 64'd4;
  assign consumed     = if_valid_q & ~stall;
  assign out_free     = ~if_valid_q | ~stall;

  // Next-state, PC, output-register and skid-buffer update rules.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pend_pc_d      = pend_pc_q;
    if_valid_d     = if_valid_q;
    if_instr_d     = if_instr_q;
    if_pc_d        = if_pc_q;
    if_nextseqpc_d = if_nextseqpc_q;
    skid_valid_d   = skid_valid_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (redirect) begin
          if_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
          if (imem_ack) begin
            // Transaction closes this edge, so the new address can go out now.
            fetch_pc_d = redir_tgt;
          end else begin
            // Read still open: keep the old address until it acks.
            pend_pc_d = redir_tgt;
            state_d   = FLUSH;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_inc;
          if (out_free) begin
            if_valid_d     = 1'b1;
            if_instr_d     = imem_rdata;
            if_pc_d        = fetch_pc_q;
            if_nextseqpc_d = fetch_pc_inc;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = fetch_pc_q;
            state_d      = HOLD;
          end
        end else if (consumed) begin
          if_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          if_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
          fetch_pc_d   = redir_tgt;
          state_d      = FETCH;
        end else if (!stall) begin
          if_valid_d     = 1'b1;
          if_instr_d     = skid_instr_q;
          if_pc_d        = skid_pc_q;
          if_nextseqpc_d = skid_pc_inc;
          skid_valid_d   = 1'b0;
          state_d        = FETCH;
        end
      end

      FLUSH: begin
        if (redirect) begin
          if_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
          pend_pc_d    = redir_tgt;
          if (imem_ack) begin
            // Newest target wins when the stale read closes on the same edge.
            fetch_pc_d = redir_tgt;
            state_d    = FETCH;
          end
        end else if (imem_ack) begin
          fetch_pc_d = pend_pc_q;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q        <= IDLE;
      fetch_pc_q     <= RESET_PC_AL;
      pend_pc_q      <= '0;
      if_valid_q     <= 1'b0;
      if_instr_q     <= '0;
      if_pc_q        <= '0;
      if_nextseqpc_q <= '0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      pend_pc_q      <= pend_pc_d;
      if_valid_q     <= if_valid_d;
      if_instr_q     <= if_instr_d;
      if_pc_q        <= if_pc_d;
      if_nextseqpc_q <= if_nextseqpc_d;
      skid_valid_q   <= skid_valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
    end
  end

  assign imem_req     = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr    = fetch_pc_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_nextseqpc = if_nextseqpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The reference model is the
// program-order stream: after reset or a redirect ID must see T, T+4, T+8 ...
// each exactly once, with instruction data equal to the low 32 address bits.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        resetl;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [63:0] if_nextseqpc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .resetl       (resetl),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_nextseqpc (if_nextseqpc)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder: latency per transaction ------------
  int unsigned mem_lat = 1;   // 0 selects a random latency 1..3 per read
  int unsigned cnt = 0;
  int unsigned cur_lat = 1;
  bit          prev_req = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (!resetl) begin
      imem_ack = 1'b0;
      cnt      = 0;
      prev_req = 1'b0;
    end else begin
      if (imem_ack) cnt = 0;
      else if (prev_req) cnt++;
      if (imem_req) begin
        if (cnt == 0) cur_lat = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
        imem_ack   = (cnt + 1 >= cur_lat);
        imem_rdata = imem_ack ? imem_addr[31:0] : $urandom;
      end else begin
        imem_ack = 1'b0;
        cnt      = 0;
      end
      prev_req = imem_req;
    end
  end

  // ---------------- scoreboard monitor (mid-cycle sampling) --------------
  logic [63:0] exp_q[$];
  int unsigned n_since_rst = 0;
  int unsigned idle_cnt = 0;
  int unsigned n_consumed = 0;
  bit          rand_phase = 1'b0;
  bit          pv_req = 1'b0;
  bit          pv_ack = 1'b0;
  logic [63:0] pv_addr = '0;

  always @(negedge clk) begin
    if (!resetl) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
      n_since_rst = 0;
      idle_cnt    = 0;
      pv_req      = 1'b0;
    end else begin
      // An open read must stay requested at the same address until acked.
      if (pv_req && !pv_ack) begin
        chkb("proto_req_held", imem_req, 1'b1);
        chk("proto_addr_stable", imem_addr, pv_addr);
      end
      pv_req  = imem_req;
      pv_ack  = imem_ack;
      pv_addr = imem_addr;

      if (if_valid && !stall) begin
        idle_cnt = 0;
        if (rand_phase) n_consumed++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got pc %h expected nothing", if_pc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", {32'h0, if_instr}, {32'h0, e[31:0]});
          chk("sb_nextseqpc", if_nextseqpc, e + 64'd4);
          if (exp_q.size() == 0) exp_q.push_back(e + 64'd4);
        end
      end else begin
        idle_cnt++;
        if (idle_cnt == 80) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_watchdog: no instruction consumed for %0d cycles", idle_cnt);
        end
      end

      // A redirect on the first edge after reset is not honoured.
      if (redirect && n_since_rst > 0) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & ~64'h3);
      end
      n_since_rst++;
    end
  end

  task automatic wait_valid(input string name, input logic [63:0] exp_pc);
    int i;
    i = 0;
    while (!if_valid && i < 40) begin
      tick();
      i++;
    end
    if (!if_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no valid output expected pc %h", name, exp_pc);
    end else begin
      chk(name, if_pc, exp_pc);
    end
  endtask

  // ---------------- directed scenarios, then random traffic --------------
  initial begin
    resetl      = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #2 resetl = 1'b0;
    #1;
    chkb("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RST_PC);
    chkb("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 64'h0);
    chk("rst_instr", {32'h0, if_instr}, 64'h0);
    chk("rst_nextseqpc", if_nextseqpc, 64'h0);
    chkb("rst_skid", dut.skid_valid_q, 1'b0);
    tick();
    tick();
    resetl = 1'b1;

    // Startup with zero-wait memory.
    tick();
    chkb("start_req", imem_req, 1'b1);
    chk("start_addr", imem_addr, 64'h1000);
    chkb("start_valid0", if_valid, 1'b0);
    tick();
    chkb("start_valid1", if_valid, 1'b1);
    chk("start_pc", if_pc, 64'h1000);
    chk("start_nextseqpc", if_nextseqpc, 64'h1004);
    tick();
    chk("seq_pc1", if_pc, 64'h1004);
    tick();
    chk("seq_pc2", if_pc, 64'h1008);
    stall = 1'b1;

    // Three stalled edges: 0x100C parks in the skid buffer.
    for (int i = 0; i < 3; i++) begin
      tick();
      chkb("hold_req", imem_req, 1'b0);
      chkb("hold_valid", if_valid, 1'b1);
      chk("hold_pc", if_pc, 64'h1008);
      chkb("hold_skid", dut.skid_valid_q, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk("drain_pc", if_pc, 64'h100C);
    chkb("drain_req", imem_req, 1'b1);
    chk("drain_addr", imem_addr, 64'h1010);
    chkb("drain_skid", dut.skid_valid_q, 1'b0);
    tick();
    chk("resume_pc", if_pc, 64'h1010);

    // Redirect with no open transaction.
    redirect    = 1'b1;
    redirect_pc = 64'h2003;
    tick();
    redirect = 1'b0;
    chkb("redir_valid0", if_valid, 1'b0);
    chk("redir_addr", imem_addr, 64'h2000);
    tick();
    chkb("redir_valid1", if_valid, 1'b1);
    chk("redir_pc", if_pc, 64'h2000);

    // Latency 3 with a held output, then asynchronous reset mid-request.
    @(negedge clk);
    mem_lat = 3;
    tick();
    chk("lat_pc", if_pc, 64'h2004);
    stall = 1'b1;
    tick();
    chkb("pend_req", imem_req, 1'b1);
    chk("pend_addr", imem_addr, 64'h2008);
    chkb("pend_valid", if_valid, 1'b1);
    @(negedge clk);
    #2 resetl = 1'b0;
    #1;
    chkb("arst_req", imem_req, 1'b0);
    chkb("arst_valid", if_valid, 1'b0);
    chkb("arst_skid", dut.skid_valid_q, 1'b0);
    chk("arst_addr", imem_addr, RST_PC);
    stall = 1'b0;
    tick();
    tick();
    resetl = 1'b1;

    // Redirect while a latency-3 read to 0x1004 is open.
    tick();
    chk("l3_addr0", imem_addr, 64'h1000);
    tick();
    tick();
    chkb("l3_valid0", if_valid, 1'b0);
    tick();
    chkb("l3_valid1", if_valid, 1'b1);
    chk("l3_pc", if_pc, 64'h1000);
    chk("l3_addr1", imem_addr, 64'h1004);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect = 1'b0;
    chkb("flush_req", imem_req, 1'b1);
    chk("flush_addr_old", imem_addr, 64'h1004);
    chkb("flush_valid", if_valid, 1'b0);
    tick();
    chk("flush_next_addr", imem_addr, 64'h3000);
    chkb("flush_valid_after", if_valid, 1'b0);

    // Two redirects, the second landing while in FLUSH.
    redirect    = 1'b1;
    redirect_pc = 64'h4000;
    tick();
    redirect_pc = 64'h5000;
    chk("dbl_addr_a", imem_addr, 64'h3000);
    tick();
    redirect = 1'b0;
    chk("dbl_addr_b", imem_addr, 64'h3000);
    tick();
    chk("dbl_addr_new", imem_addr, 64'h5000);
    wait_valid("dbl_pc", 64'h5000);

    // PC wrap at 2^64.
    @(negedge clk);
    mem_lat = 1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_valid("wrap_pc", 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_nextseqpc", if_nextseqpc, 64'h0);
    chk("wrap_addr", imem_addr, 64'h0);
    tick();
    wait_valid("wrap_pc0", 64'h0);

    // Random traffic: stall, latency and redirects all vary.
    @(negedge clk);
    mem_lat    = 0;
    rand_phase = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        redirect_pc = {$urandom, $urandom};
    end
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    rand_phase = 1'b0;
    chkb("rand_throughput", n_consumed >= 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
